rtc_calendar_counter: RTL and testbench
=======================================

// Module: rtc_calendar_counter
// PURPOSE
//   Free-running BCD month/day/hour/minute/second clock, downstream of the time-setting stage.
//   Consumes that stage's packed MMDDHHMM value and load flag, validates the value, and loads it.
//   Advances once per second from a clock prescaler, with full calendar rollover.
//   Feeds the display/alarm logic with registered BCD time and a one-cycle second tick.
// PARAMETERS
//   TICK_DIV   50_000_000  clk cycles per second; legal range >= 2
// PORTS
//   clk          in   1   system clock, all logic on posedge
//   rstb         in   1   synchronous active-low reset, sampled on posedge clk
//   set_time     in   1   load request level, from the time-setting stage's set_time_mode
//   time_in      in   32  BCD {Mt,Mu,Dt,Du,Ht,Hu,mt,mu}, 4 bits per digit
//   time_out     out  32  current BCD time, same packing as time_in
//   sec_out      out  8   current seconds, BCD {St,Su}
//   sec_tick     out  1   1-cycle pulse in the cycle the time advances
//   load_ok      out  1   1-cycle pulse: time_in accepted
//   load_err     out  1   1-cycle pulse: time_in rejected as invalid
// BEHAVIOUR
// - Clock and reset
//   - One clock only: clk. Reset is synchronous, active-low, on rstb.
//   - rstb=0 at posedge sets: time_out=32'h0101_0000 (Jan 01 00:00), sec_out=8'h00.
//   - It also clears the prescaler, the internal copies of set_time/time_in, sec_tick, load_ok and load_err.
//   - Reset applies on any cycle, including mid-load and mid-rollover; no partial update survives it.
// - Prescaler
//   - Counts 0..TICK_DIV-1 and wraps to 0.
//   - Terminal count sets sec_tick=1 in the next cycle, together with the updated time.
// - Load detection
//   - set_time and time_in are registered once internally.
//   - A load event occurs when set_time=1 and either:
//     - the registered set_time=0 (rising edge), or
//     - time_in differs from the registered time_in.
//   - The upstream stage holds set_time high once set and re-presents a new value on each press; this rule loads every new value.
// - Validation (combinational on time_in)
//   - Every digit must be <= 9.
//   - Month must be 01..12.
//   - Day must be 01..DIM(month): DIM = 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; 28 for 2. There are no leap years.
//   - Hour must be 00..23 and minute 00..59.
// - Load response, 1 cycle after the triggering edge
//   - Valid value: time_out<=time_in, sec_out<=8'h00, prescaler<=0, load_ok pulses.
//   - Invalid value: time unchanged, load_err pulses, prescaler keeps running.
//   - Load has priority over a tick in the same cycle: the tick is dropped and sec_tick stays 0.
// - Increment (BCD, ripple carry within one cycle)
//   - Su 9->0 carries into St; St:Su 59->00 carries into minute.
//   - Minute 59->00 carries into hour. Hour 23->00 carries into day.
//   - Day == DIM(month) -> 01 and carries into month.
//   - Month 12->01.
//   - Dec 31 23:59:59 -> Jan 01 00:00:00 in a single tick.
// - Outputs are registered. sec_tick, load_ok and load_err are never high together.
// TESTING
//   1. TICK_DIV=4, reset -> time_out=32'h01010000, sec_out=00; sec_tick exactly every 4th cycle.
//   2. Load 32'h02281959 valid -> load_ok pulse 1 cycle later; after 60 ticks time_out=32'h02282000.
//   3. Load 32'h12312359, run 60 ticks -> at tick 60 time_out=32'h01010000, sec_out=00, all in one cycle.
//   4. Load 32'h02300000 (Feb 30), then 32'h13010000 and 32'h010100A0 -> load_err each; time unchanged.
//   5. set_time held 1, time_in 32'h04301200 -> 32'h04301201 -> two load_ok pulses; load on the tick cycle -> no sec_tick, sec_out=00.
//   6. Drop rstb for 1 cycle mid-count after a load -> time_out=32'h01010000, prescaler restarts from 0.

Source files
------------

// File: rtl/rtc_calendar_counter.sv
// rtl/rtc_calendar_counter.sv - BCD month/day/hour/minute/second calendar clock with validated load
module rtc_calendar_counter #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        set_time,
    input  logic [31:0] time_in,
    output logic [31:0] time_out,
    output logic [7:0]  sec_out,
    output logic        sec_tick,
    output logic        load_ok,
    output logic        load_err
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic          set_q;
    logic [31:0]   tin_q;

    logic          terminal;
    logic          load_evt;
    logic          digits_ok;
    logic          time_valid;

    logic [3:0] mot, mou, dt, du, ht, hu, mt, mu, st, su;
    logic [3:0] n_mot, n_mou, n_dt, n_du, n_ht, n_hu, n_mt, n_mu, n_st, n_su;
    logic       c_min, c_hour, c_day, c_mon;

    // Days in month for a BCD month; no leap years, unknown months fall to 31
    function automatic logic [7:0] dim_of(input logic [7:0] month);
        case (month)
            8'h02:                      dim_of = 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: dim_of = 8'h30;
            default:                    dim_of = 8'h31;
        endcase
    endfunction

    assign terminal = (presc == PRESC_LAST);
    // New value while set_time is held also counts as a load, so every press is taken
    assign load_evt = set_time && (!set_q || (time_in != tin_q));

    // Range-check the presented value; byte compares are valid once every digit is decimal
    always_comb begin
        digits_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (time_in[4*i +: 4] > 4'd9) digits_ok = 1'b0;
        end
        time_valid = digits_ok
                  && (time_in[31:24] >= 8'h01) && (time_in[31:24] <= 8'h12)
                  && (time_in[23:16] >= 8'h01) && (time_in[23:16] <= dim_of(time_in[31:24]))
                  && (time_in[15:8]  <= 8'h23)
                  && (time_in[7:0]   <= 8'h59);
    end

    // One-second increment with ripple carry through the whole calendar
    always_comb begin
        {mot, mou, dt, du, ht, hu, mt, mu} = time_out;
        {st, su} = sec_out;
        {n_mot, n_mou, n_dt, n_du, n_ht, n_hu, n_mt, n_mu} = time_out;
        {n_st, n_su} = sec_out;
        c_min  = 1'b0;
        c_hour = 1'b0;
        c_day  = 1'b0;
        c_mon  = 1'b0;

        if (su == 4'd9) begin
            n_su = 4'd0;
            if (st == 4'd5) begin
                n_st  = 4'd0;
                c_min = 1'b1;
            end else begin
                n_st = st + 4'd1;
            end
        end else begin
            n_su = su + 4'd1;
        end

        if (c_min) begin
            if (mu == 4'd9) begin
                n_mu = 4'd0;
                if (mt == 4'd5) begin
                    n_mt   = 4'd0;
                    c_hour = 1'b1;
                end else begin
                    n_mt = mt + 4'd1;
                end
            end else begin
                n_mu = mu + 4'd1;
            end
        end

        if (c_hour) begin
            if ({ht, hu} == 8'h23) begin
                n_ht  = 4'd0;
                n_hu  = 4'd0;
                c_day = 1'b1;
            end else if (hu == 4'd9) begin
                n_hu = 4'd0;
                n_ht = ht + 4'd1;
            end else begin
                n_hu = hu + 4'd1;
            end
        end

        if (c_day) begin
            if ({dt, du} == dim_of({mot, mou})) begin
                n_dt  = 4'd0;
                n_du  = 4'd1;
                c_mon = 1'b1;
            end else if (du == 4'd9) begin
                n_du = 4'd0;
                n_dt = dt + 4'd1;
            end else begin
                n_du = du + 4'd1;
            end
        end

        if (c_mon) begin
            if ({mot, mou} == 8'h12) begin
                n_mot = 4'd0;
                n_mou = 4'd1;
            end else if (mou == 4'd9) begin
                n_mot = 4'd1;
                n_mou = 4'd0;
            end else begin
                n_mou = mou + 4'd1;
            end
        end
    end

    // Prescaler, load handling and time update; a load in a tick cycle swallows the tick
    always_ff @(posedge clk) begin
        if (!rstb) begin
            presc    <= '0;
            set_q    <= 1'b0;
            tin_q    <= 32'h0;
            time_out <= 32'h0101_0000;
            sec_out  <= 8'h00;
            sec_tick <= 1'b0;
            load_ok  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            set_q    <= set_time;
            tin_q    <= time_in;
            sec_tick <= 1'b0;
            load_ok  <= 1'b0;
            load_err <= 1'b0;
            presc    <= terminal ? '0 : presc + 1'b1;
            if (load_evt) begin
                if (time_valid) begin
                    time_out <= time_in;
                    sec_out  <= 8'h00;
                    presc    <= '0;
                    load_ok  <= 1'b1;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (terminal) begin
                time_out <= {n_mot, n_mou, n_dt, n_du, n_ht, n_hu, n_mt, n_mu};
                sec_out  <= {n_st, n_su};
                sec_tick <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rtc_calendar_counter.sv
// tb/tb_rtc_calendar_counter.sv - directed scoreboard bench for rtc_calendar_counter
module tb_rtc_calendar_counter;

    localparam int TICK_DIV = 4;

    logic        clk;
    logic        rstb;
    logic        set_time;
    logic [31:0] time_in;
    logic [31:0] time_out;
    logic [7:0]  sec_out;
    logic        sec_tick;
    logic        load_ok;
    logic        load_err;

    typedef struct packed {
        logic [31:0] t;
        logic [7:0]  s;
        logic        tick;
        logic        ok;
        logic        err;
    } exp_t;

    exp_t  sb[$];
    string tags[$];
    int    checks = 0;
    int    errors = 0;

    rtc_calendar_counter #(.TICK_DIV(TICK_DIV)) dut (
        .clk      (clk),
        .rstb     (rstb),
        .set_time (set_time),
        .time_in  (time_in),
        .time_out (time_out),
        .sec_out  (sec_out),
        .sec_tick (sec_tick),
        .load_ok  (load_ok),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_field(input string tag, input string field,
                               input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp_v);
        end
    endtask

    task automatic expect_state(input string tag, input logic [31:0] t, input logic [7:0] s,
                                input logic tick, input logic ok, input logic err);
        exp_t e;
        e.t = t; e.s = s; e.tick = tick; e.ok = ok; e.err = err;
        sb.push_back(e);
        tags.push_back(tag);
    endtask

    task automatic check_pop();
        exp_t  e;
        string tag;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e   = sb.pop_front();
            tag = tags.pop_front();
            check_field(tag, "time_out", time_out, e.t);
            check_field(tag, "sec_out", {24'h0, sec_out}, {24'h0, e.s});
            check_field(tag, "sec_tick", {31'h0, sec_tick}, {31'h0, e.tick});
            check_field(tag, "load_ok", {31'h0, load_ok}, {31'h0, e.ok});
            check_field(tag, "load_err", {31'h0, load_err}, {31'h0, e.err});
        end
    endtask

    task automatic wait_ticks(input int n);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < n * TICK_DIV + 8) begin
            step();
            cyc++;
            if (sec_tick === 1'b1) seen++;
        end
        checks++;
        assert (seen == n) else begin
            errors++;
            $error("FAIL tick_wait observed=%0d expected=%0d", seen, n);
        end
    endtask

    initial begin
        rstb     = 1'b0;
        set_time = 1'b0;
        time_in  = 32'h0;

        // Reset state
        expect_state("reset0", 32'h0101_0000, 8'h00, 1'b0, 1'b0, 1'b0);
        step(); check_pop();
        expect_state("reset1", 32'h0101_0000, 8'h00, 1'b0, 1'b0, 1'b0);
        step(); check_pop();
        rstb = 1'b1;

        // Tick every 4th cycle after release, seconds counting up
        for (int i = 0; i < 12; i++) begin
            expect_state("cadence", 32'h0101_0000, 8'((i + 1) / 4), (i % 4) == 3, 1'b0, 1'b0);
            step(); check_pop();
        end

        // Valid load, then minute and hour carry
        set_time = 1'b1;
        time_in  = 32'h0228_1959;
        expect_state("load_feb28", 32'h0228_1959, 8'h00, 1'b0, 1'b1, 1'b0);
        step(); check_pop();
        wait_ticks(59);
        expect_state("feb28_59s", 32'h0228_1959, 8'h59, 1'b1, 1'b0, 1'b0);
        check_pop();
        wait_ticks(1);
        expect_state("feb28_carry", 32'h0228_2000, 8'h00, 1'b1, 1'b0, 1'b0);
        check_pop();

        // Year-end rollover in one tick
        set_time = 1'b0;
        step();
        set_time = 1'b1;
        time_in  = 32'h1231_2359;
        expect_state("load_dec31", 32'h1231_2359, 8'h00, 1'b0, 1'b1, 1'b0);
        step(); check_pop();
        wait_ticks(59);
        expect_state("dec31_59s", 32'h1231_2359, 8'h59, 1'b1, 1'b0, 1'b0);
        check_pop();
        wait_ticks(1);
        expect_state("new_year", 32'h0101_0000, 8'h00, 1'b1, 1'b0, 1'b0);
        check_pop();

        // Invalid values rejected; last one lands on a tick cycle
        set_time = 1'b0;
        step();
        set_time = 1'b1;
        time_in  = 32'h0230_0000;
        expect_state("err_feb30", 32'h0101_0000, 8'h00, 1'b0, 1'b0, 1'b1);
        step(); check_pop();
        time_in = 32'h1301_0000;
        expect_state("err_month13", 32'h0101_0000, 8'h00, 1'b0, 1'b0, 1'b1);
        step(); check_pop();
        time_in = 32'h0101_00A0;
        expect_state("err_digit", 32'h0101_0000, 8'h00, 1'b0, 1'b0, 1'b1);
        step(); check_pop();
        step(); step(); step();
        expect_state("after_err_tick", 32'h0101_0000, 8'h01, 1'b1, 1'b0, 1'b0);
        step(); check_pop();

        // Held set_time with new values; load colliding with a tick
        set_time = 1'b0;
        step();
        set_time = 1'b1;
        time_in  = 32'h0430_1200;
        expect_state("held_load1", 32'h0430_1200, 8'h00, 1'b0, 1'b1, 1'b0);
        step(); check_pop();
        time_in = 32'h0430_1201;
        expect_state("held_load2", 32'h0430_1201, 8'h00, 1'b0, 1'b1, 1'b0);
        step(); check_pop();
        for (int i = 0; i < 3; i++) begin
            expect_state("held_idle", 32'h0430_1201, 8'h00, 1'b0, 1'b0, 1'b0);
            step(); check_pop();
        end
        time_in = 32'h0430_1202;
        expect_state("load_on_tick", 32'h0430_1202, 8'h00, 1'b0, 1'b1, 1'b0);
        step(); check_pop();
        for (int i = 0; i < 4; i++) begin
            expect_state("post_load_cadence", 32'h0430_1202, (i == 3) ? 8'h01 : 8'h00,
                         i == 3, 1'b0, 1'b0);
            step(); check_pop();
        end

        // Reset mid-count after a load
        time_in = 32'h1115_2030;
        expect_state("load_nov15", 32'h1115_2030, 8'h00, 1'b0, 1'b1, 1'b0);
        step(); check_pop();
        step(); step();
        rstb     = 1'b0;
        set_time = 1'b0;
        expect_state("mid_reset", 32'h0101_0000, 8'h00, 1'b0, 1'b0, 1'b0);
        step(); check_pop();
        rstb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_state("restart_cadence", 32'h0101_0000, (i == 3) ? 8'h01 : 8'h00,
                         i == 3, 1'b0, 1'b0);
            step(); check_pop();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
